// File: rtl/os_array_drain.sv
// Result drain for the output-stationary array: snapshots every PE accumulator when a tile
// finishes, then streams rescaled, narrowed results in row-major order over valid/ready.
//
// state  | meaning
// IDLE   | waiting for start_i; a start captures the accumulator snapshot
// STREAM | presenting snapshot[row][col]; each handshake advances to the next element
// DONE   | single-cycle done_o pulse after the last element is accepted
module os_array_drain #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [N*N*ACC_WIDTH-1:0]   acc_i,
    output logic                       clr_o,
    output logic                       busy_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OUT_WIDTH-1:0]       out_data_o,
    output logic [$clog2(N)-1:0]       out_row_o,
    output logic [$clog2(N)-1:0]       out_col_o,
    output logic                       out_last_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int CW = $clog2(N);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               row_q, col_q;
    logic                        clr_q, err_q;
    logic signed [ACC_WIDTH-1:0] snap_q [N][N];
    logic                        accept, handshake, is_last;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]        narrowed;

    assign accept    = (state_q == S_IDLE) && start_i;
    assign handshake = (state_q == S_STREAM) && out_ready_i;
    assign is_last   = (row_q == CW'(N-1)) && (col_q == CW'(N-1));

    // Snapshot bank carries no reset; it is only observable after a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    snap_q[r][c] <= acc_i[(r*N+c)*ACC_WIDTH +: ACC_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            clr_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            clr_q <= accept;
            if (start_i && (state_q != S_IDLE)) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                row_q <= '0;
                col_q <= '0;
            end else if (handshake && !is_last) begin
                if (col_q == CW'(N-1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                out_last_o  = is_last;
                if (out_ready_i && is_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Rescale then narrow: clamp to the signed output range, or keep the low bits.
    always_comb begin
        shifted  = snap_q[row_q][col_q] >>> SHIFT;
        narrowed = shifted[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (shifted > SAT_MAX) begin
                narrowed = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
                narrowed = SAT_MIN[OUT_WIDTH-1:0];
            end
        end
    end

    assign out_data_o = (state_q == S_STREAM) ? narrowed : '0;
    assign out_row_o  = (state_q == S_STREAM) ? row_q : '0;
    assign out_col_o  = (state_q == S_STREAM) ? col_q : '0;
    assign clr_o      = clr_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_os_array_drain.sv
// Bench for os_array_drain: three instances (saturate, truncate, shift-by-8) share one stimulus
// stream and are checked every cycle against a queue-free arithmetic reference of the drain.
module tb_os_array_drain;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int OW = 32;
    localparam int NE = N * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            out_ready_i;
    logic [NE*AW-1:0] acc_i;

    logic            clr   [3];
    logic            busy  [3];
    logic            valid [3];
    logic            last  [3];
    logic            done  [3];
    logic            err   [3];
    logic [OW-1:0]   data  [3];
    logic [1:0]      row   [3];
    logic [1:0]      col   [3];

    int    total = 0;
    int    bad   = 0;
    longint snap_m [NE];
    bit    err_exp;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            os_array_drain #(
                .N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
                .SHIFT((g == 2) ? 8 : 0), .SATURATE((g == 1) ? 0 : 1)
            ) dut (
                .clk(clk), .rst(rst), .start_i(start_i), .acc_i(acc_i),
                .clr_o(clr[g]), .busy_o(busy[g]), .out_valid_o(valid[g]),
                .out_ready_i(out_ready_i), .out_data_o(data[g]),
                .out_row_o(row[g]), .out_col_o(col[g]), .out_last_o(last[g]),
                .done_o(done[g]), .err_o(err[g])
            );
        end
    endgenerate

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference narrowing: instance 0 saturates, 1 truncates, 2 shifts by 8 and saturates.
    function automatic logic [31:0] narrow(input int inst, input longint a);
        longint s;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< 31) - 1;
        minv = -(longint'(1) <<< 31);
        s = a >>> ((inst == 2) ? 8 : 0);
        if (inst != 1) begin
            if (s > maxv) s = maxv;
            else if (s < minv) s = minv;
        end
        return s[31:0];
    endfunction

    function automatic longint rand_acc();
        longint v;
        v = longint'({$urandom, $urandom});
        return v >>> $urandom_range(0, 63);
    endfunction

    task automatic check_idle(input string tag, input bit done_e, input bit busy_e);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), valid[i], 0);
            chk($sformatf("%s_clr%0d", tag, i), clr[i], 0);
            chk($sformatf("%s_last%0d", tag, i), last[i], 0);
            chk($sformatf("%s_done%0d", tag, i), done[i], done_e);
            chk($sformatf("%s_busy%0d", tag, i), busy[i], busy_e);
            chk($sformatf("%s_data%0d", tag, i), data[i], 0);
            chk($sformatf("%s_rc%0d", tag, i), {row[i], col[i]}, 0);
            chk($sformatf("%s_err%0d", tag, i), err[i], err_exp);
        end
    endtask

    task automatic check_beat(input int beat, input bit first);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d_b%0d", i, beat), valid[i], 1);
            chk($sformatf("busy%0d_b%0d", i, beat), busy[i], 1);
            chk($sformatf("done%0d_b%0d", i, beat), done[i], 0);
            chk($sformatf("clr%0d_b%0d", i, beat), clr[i], first);
            chk($sformatf("last%0d_b%0d", i, beat), last[i], (beat == NE - 1));
            chk($sformatf("row%0d_b%0d", i, beat), row[i], beat / N);
            chk($sformatf("col%0d_b%0d", i, beat), col[i], beat % N);
            chk($sformatf("data%0d_b%0d", i, beat), data[i], narrow(i, snap_m[beat]));
            chk($sformatf("err%0d_b%0d", i, beat), err[i], err_exp);
        end
    endtask

    // mode 0: ready held high, 1: ready toggles 1,0,..., 2: random ready.
    task automatic run_drain(input int mode, input int busy_beat, input int rst_beat);
        int beat;
        int cyc;
        bit first;
        bit pulsed;
        bit r;
        for (int i = 0; i < NE; i++) acc_i[i*AW +: AW] = snap_m[i];
        start_i     = 1'b1;
        out_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < NE; i++) acc_i[i*AW +: AW] = {$urandom, $urandom};
        beat = 0; cyc = 0; first = 1'b1; pulsed = 1'b0;
        while (beat < NE && cyc < 400) begin
            check_beat(beat, first);
            if (beat == rst_beat) begin
                rst = 1'b1;
                out_ready_i = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                err_exp = 1'b0;
                check_idle("rst_abort", 1'b0, 1'b0);
                return;
            end
            if (beat == busy_beat && !pulsed) begin
                start_i = 1'b1;
                pulsed  = 1'b1;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            out_ready_i = r;
            @(negedge clk);
            start_i = 1'b0;
            if (pulsed) err_exp = 1'b1;
            if (r) beat++;
            first = 1'b0;
            cyc++;
        end
        chk("beats_drained", beat, NE);
        out_ready_i = 1'($urandom_range(0, 1));
        check_idle("done_cycle", 1'b1, 1'b1);
        @(negedge clk);
        check_idle("after_done", 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        acc_i       = '0;
        err_exp     = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle", 1'b0, 1'b0);

        for (int i = 0; i < NE; i++) snap_m[i] = 3 * i;
        run_drain(0, -1, -1);
        run_drain(1, -1, -1);

        snap_m[0] = longint'(1) <<< 40;
        snap_m[1] = -(longint'(1) <<< 40);
        snap_m[2] = -5;
        snap_m[3] = (longint'(1) <<< 31) - 1;
        snap_m[4] = (longint'(1) <<< 40) + 7;
        snap_m[5] = -256;
        snap_m[6] = 64'h1FF;
        snap_m[7] = -1;
        for (int i = 8; i < NE; i++) snap_m[i] = rand_acc();
        run_drain(2, -1, -1);

        for (int i = 0; i < NE; i++) snap_m[i] = rand_acc();
        run_drain(0, 5, -1);
        chk("err_sticky", err[0], 1);
        for (int i = 0; i < NE; i++) snap_m[i] = rand_acc();
        run_drain(2, -1, -1);

        for (int i = 0; i < NE; i++) snap_m[i] = rand_acc();
        run_drain(2, -1, 6);
        for (int i = 0; i < NE; i++) snap_m[i] = rand_acc();
        run_drain(0, -1, -1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NE; i++) snap_m[i] = rand_acc();
            run_drain(2, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
